bias_accumulator_array: RTL and testbench
=========================================

Name: bias_accumulator_array

Overview:
Parametrised, handshaked successor to the fixed 20-channel layer bias adder. Preloads NUM_CH signed accumulators with per-channel biases, then accumulates exactly NUM_BEATS valid input vectors with signed saturation. Presents the result vector under a valid/ready handshake to the next layer. Sits between a layer's MAC array and its activation/next-layer stage; biases are runtime-writable as well as file-initialised.

Parameters:
NUM_CH, 20, number of channels (accumulators)
SIZE, 16, accumulator/input/output width per channel, signed two's complement
BIAS_SIZE, 8, stored bias width, signed
BIAS_SHIFT, 0, left shift applied to the sign-extended bias at preload (fixed-point alignment), 0..SIZE-BIAS_SIZE
NUM_BEATS, 16, input vectors accumulated per run, >=1
BIAS_FILE, "", $readmemb init file for the bias store; empty string means store initialises to zero
CW, $clog2(NUM_CH) (min 1), bias address width (localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  begin a run: preload biases, clear beat count
busy  out  1  high in PRELOAD and ACCUM
in_valid  in  1  input vector valid
in_ready  out  1  high only in ACCUM
in_data  in  NUM_CH*SIZE  packed input, channel i at [i*SIZE +: SIZE]
bias_wr_en  in  1  bias store write strobe
bias_wr_addr  in  CW  channel index to write
bias_wr_data  in  BIAS_SIZE  new bias value
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  NUM_CH*SIZE  packed accumulators, same packing as in_data

Behaviour:
- Reset: state IDLE, all accumulators 0, beat counter 0, out_valid 0, busy 0, in_ready 0. Bias store is not reset.
- FSM IDLE -> PRELOAD on start. PRELOAD (1 cycle): acc[i] <= sext(bias[i]) << BIAS_SHIFT; counter <= 0; -> ACCUM.
- ACCUM: in_ready=1; beat accepted when in_valid&&in_ready; acc[i] <= sat(acc[i]+in[i]); counter++. On beat NUM_BEATS-1 -> HOLD. No accepted beat: all state held.
- HOLD: out_valid=1, out_data stable. out_ready -> IDLE; out_ready && start same cycle -> PRELOAD (back-to-back runs). start without out_ready in HOLD ignored.
- start in PRELOAD/ACCUM ignored (no restart mid-run).
- Saturation: sum computed at SIZE+1 bits; above 2^(SIZE-1)-1 clamps to 0x7FFF-style max, below -2^(SIZE-1) clamps to min. Per channel, independent.
- Latency: result valid the cycle after the final accepted beat; run minimum 1+NUM_BEATS cycles start-to-out_valid.
- Bias writes accepted in every state; write address >= NUM_CH ignored. Write in the same cycle as PRELOAD: PRELOAD uses the old value; new value applies to the next run.
- Accumulators retain value in IDLE (out_data readable but out_valid=0).
- Reset mid-run aborts immediately to the reset state; bias store contents preserved.

Optional Feature:
BIAS_ACC_RELU_EN: when defined, out_data channels with negative accumulator value are driven 0 (accumulator itself unchanged, saturation unchanged). When undefined, out_data is the raw accumulator.

Decomposition:
- Shared package nn_layer_pkg: FSM state enum (IDLE, PRELOAD, ACCUM, HOLD), signed saturating-add function parameterised on width, sign-extend/shift helper.
- One sub-module natural: sat_acc_lane (one channel: preload, saturating add, optional ReLU output), generated NUM_CH times; FSM, counter and bias store live in the top.

Test Plan:
- Defaults, bias[0]=8'h05, BIAS_SHIFT=0, start, 16 beats of in[0]=1 -> out_valid after final beat, out[0]=21 (0x0015); other channels bias+16.
- in[3]=0x7000 for 2 beats, bias 0 -> out[3]=0x7FFF (positive saturation); in[4]=0x9000 x2 -> 0x8000.
- in_valid toggled 1/0 every cycle for 16 beats -> out_valid exactly after 16th accepted beat (31 cycles after PRELOAD), counter not advanced on idle cycles.
- HOLD with out_ready=0 for 5 cycles -> out_valid and out_data stable; out_ready=1 with start=1 -> next cycle PRELOAD, busy=1, no IDLE cycle.
- bias_wr_en addr 2 data 8'hFE same cycle as PRELOAD -> run uses old bias; next run out[2] starts at -2; BIAS_SHIFT=4 gives preload 0xFFE0.
- reset asserted at beat 7 -> next cycle out_valid=0, accumulators 0, state IDLE; restart yields correct result using preserved biases; with BIAS_ACC_RELU_EN, out[5] accumulating to -3 reads 0.

Source files
------------

// File: rtl/nn_layer_pkg.sv
// nn_layer_pkg: shared FSM state type and signed saturating/alignment helpers for layer datapaths
package nn_layer_pkg;
  typedef enum logic [1:0] {IDLE, PRELOAD, ACCUM, HOLD} state_t;
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [63:0] s, mx, mn;
    s = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    return (s > mx) ? mx : ((s < mn) ? mn : s);
  endfunction
  function automatic logic signed [63:0] sext_shl(input logic signed [63:0] v, input int sh);
    return v <<< sh;
  endfunction
endpackage

// File: rtl/sat_acc_lane.sv
// sat_acc_lane: one channel accumulator with preload, signed saturating add and optional ReLU output (BIAS_ACC_RELU_EN)
module sat_acc_lane
  import nn_layer_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic signed [SIZE-1:0] i_load_val,
  input  logic                   i_add,
  input  logic signed [SIZE-1:0] i_in,
  output logic        [SIZE-1:0] o_data
);
  logic signed [SIZE-1:0] r_acc;
  // preload has priority; otherwise add an accepted beat with clamping at the signed range
  always_ff @(posedge clk)
    if (reset) r_acc <= '0;
    else if (i_load) r_acc <= i_load_val;
    else if (i_add) r_acc <= SIZE'(sat_add(64'(r_acc), 64'(i_in), SIZE));
`ifdef BIAS_ACC_RELU_EN
  assign o_data = r_acc[SIZE-1] ? '0 : r_acc;
`else
  assign o_data = r_acc;
`endif
endmodule

// File: rtl/bias_accumulator_array.sv
// bias_accumulator_array: bias preload + NUM_BEATS saturating accumulations per run, result under valid/ready (ReLU via BIAS_ACC_RELU_EN)
module bias_accumulator_array
  import nn_layer_pkg::*;
#(
  parameter int    NUM_CH     = 20,
  parameter int    SIZE       = 16,
  parameter int    BIAS_SIZE  = 8,
  parameter int    BIAS_SHIFT = 0,
  parameter int    NUM_BEATS  = 16,
  parameter string BIAS_FILE  = "",
  localparam int   CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CH*SIZE-1:0] in_data,
  input  logic                   bias_wr_en,
  input  logic [CW-1:0]          bias_wr_addr,
  input  logic [BIAS_SIZE-1:0]   bias_wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CH*SIZE-1:0] out_data
);
  localparam int NW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  state_t r_state, w_next;
  logic [NW-1:0] r_cnt;
  logic w_load, w_beat, w_last;
  logic signed [BIAS_SIZE-1:0] r_bias [NUM_CH] = '{default: '0};
  // bias store: writable in any state, out-of-range addresses dropped, never reset
  always_ff @(posedge clk)
    if (bias_wr_en && 32'(bias_wr_addr) < NUM_CH) r_bias[bias_wr_addr] <= bias_wr_data;
  // state register and beat counter
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_load ? '0 : (w_beat ? r_cnt + 1'b1 : r_cnt);
    end
  // next state and handshake outputs
  always_comb begin
    w_load    = r_state == PRELOAD;
    in_ready  = r_state == ACCUM;
    out_valid = r_state == HOLD;
    busy      = w_load || in_ready;
    w_beat    = in_ready && in_valid;
    w_last    = r_cnt == NW'(NUM_BEATS - 1);
    w_next    = (r_state == IDLE)    ? (start ? PRELOAD : IDLE) :
                (r_state == PRELOAD) ? ACCUM :
                (r_state == ACCUM)   ? ((w_beat && w_last) ? HOLD : ACCUM) :
                (out_ready ? (start ? PRELOAD : IDLE) : HOLD);
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    sat_acc_lane #(.SIZE(SIZE)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (SIZE'(sext_shl(64'(r_bias[i]), BIAS_SHIFT))),
      .i_add      (w_beat),
      .i_in       (in_data[i*SIZE +: SIZE]),
      .o_data     (out_data[i*SIZE +: SIZE])
    );
  end
endmodule

// File: tb/tb_bias_accumulator_array.sv
// tb_bias_accumulator_array: directed self-checking bench for bias_accumulator_array (expectations honour BIAS_ACC_RELU_EN)
module tb_bias_accumulator_array;
  localparam int NC = 20;
  localparam int SZ = 16;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, out_ready = 0, bias_wr_en = 0;
  logic [4:0] bias_wr_addr = '0;
  logic [7:0] bias_wr_data = '0;
  logic [NC*SZ-1:0] in_data = '0;
  logic busy, in_ready, out_valid;
  logic [NC*SZ-1:0] out_data;
  logic s_start = 0, s_in_valid = 0, s_out_ready = 0, s_wr_en = 0;
  logic [1:0] s_wr_addr = '0;
  logic [7:0] s_wr_data = '0;
  logic [63:0] s_in_data = '0;
  logic s_busy, s_in_ready, s_out_valid;
  logic [63:0] s_out_data;
  int tests = 0, fails = 0;

  bias_accumulator_array u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  bias_accumulator_array #(.NUM_CH(4), .BIAS_SHIFT(4), .NUM_BEATS(1)) u_dut_s (
    .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .bias_wr_en(s_wr_en), .bias_wr_addr(s_wr_addr), .bias_wr_data(s_wr_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ch(input logic [NC*SZ-1:0] v, input int i);
    return v[i*SZ +: SZ];
  endfunction

  function automatic logic [15:0] rl(input logic [15:0] v);
`ifdef BIAS_ACC_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < NC; i++) in_data[i*SZ +: SZ] = v;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    bias_wr_en = 1; bias_wr_addr = 5'(a); bias_wr_data = d;
    tick();
    bias_wr_en = 0;
  endtask

  task automatic begin_run();
    start = 1;
    tick();
    start = 0;
    tick();
  endtask

  task automatic beats(input int n);
    in_valid = 1;
    repeat (n) tick();
    in_valid = 0;
  endtask

  task automatic finish_run();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL reset_s_out_valid: got %b want 0", s_out_valid); end
    reset = 0;
    tick();
  endtask

  task automatic test_accumulate();
    wr(0, 8'h05);
    start = 1;
    tick();
    start = 0;
    tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL preload_flags: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL accum_in_ready: got %b want 1", in_ready); end
    set_all(16'd1);
    beats(15);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL early_out_valid: got %b want 0", out_valid); end
    beats(1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL acc_out_valid: got %b want 1", out_valid); end
    tests++; if (ch(out_data, 0) !== 16'h0015) begin fails++; $display("FAIL acc_ch0: got %h want 0015", ch(out_data, 0)); end
    tests++; if (ch(out_data, 1) !== 16'h0010) begin fails++; $display("FAIL acc_ch1: got %h want 0010", ch(out_data, 1)); end
    tests++; if (ch(out_data, 19) !== 16'h0010) begin fails++; $display("FAIL acc_ch19: got %h want 0010", ch(out_data, 19)); end
    finish_run();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
    tests++; if (ch(out_data, 0) !== 16'h0015) begin fails++; $display("FAIL idle_retain: got %h want 0015", ch(out_data, 0)); end
  endtask

  task automatic test_saturation();
    begin_run();
    in_data = '0;
    in_data[3*SZ +: SZ] = 16'h7000;
    in_data[4*SZ +: SZ] = 16'h9000;
    beats(2);
    in_data = '0;
    beats(14);
    tests++; if (ch(out_data, 3) !== 16'h7FFF) begin fails++; $display("FAIL sat_pos: got %h want 7fff", ch(out_data, 3)); end
    tests++; if (ch(out_data, 4) !== rl(16'h8000)) begin fails++; $display("FAIL sat_neg: got %h want %h", ch(out_data, 4), rl(16'h8000)); end
    tests++; if (ch(out_data, 0) !== 16'h0005) begin fails++; $display("FAIL sat_ch0: got %h want 0005", ch(out_data, 0)); end
    tests++; if (ch(out_data, 1) !== 16'h0000) begin fails++; $display("FAIL sat_ch1: got %h want 0000", ch(out_data, 1)); end
    finish_run();
  endtask

  task automatic test_toggle();
    begin_run();
    set_all(16'd2);
    for (int k = 0; k < 31; k++) begin
      in_valid = (k % 2 == 0);
      tick();
      if (k == 1) begin
        tests++; if (ch(out_data, 1) !== 16'h0002) begin fails++; $display("FAIL toggle_idle_hold: got %h want 0002", ch(out_data, 1)); end
      end
      if (k == 29) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL toggle_early: got %b want 0", out_valid); end
      end
    end
    in_valid = 0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL toggle_out_valid: got %b want 1", out_valid); end
    tests++; if (ch(out_data, 1) !== 16'h0020) begin fails++; $display("FAIL toggle_ch1: got %h want 0020", ch(out_data, 1)); end
    tests++; if (ch(out_data, 0) !== 16'h0025) begin fails++; $display("FAIL toggle_ch0: got %h want 0025", ch(out_data, 0)); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    start = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++; if (out_valid !== 1'b1 || ch(out_data, 0) !== 16'h0025) begin fails++; $display("FAIL hold_stable: got v=%b d=%h want 1/0025", out_valid, ch(out_data, 0)); end
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    start = 0;
    tests++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL b2b_preload: got busy=%b ov=%b ir=%b want 1/0/0", busy, out_valid, in_ready); end
    wr(2, 8'hFE);
    wr(20, 8'h7F);
    in_data = '0;
    beats(8);
    start = 1;
    beats(1);
    start = 0;
    beats(6);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL restart_ignored: got %b want 0", out_valid); end
    beats(1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_out_valid: got %b want 1", out_valid); end
    tests++; if (ch(out_data, 2) !== 16'h0000) begin fails++; $display("FAIL bias_old: got %h want 0000", ch(out_data, 2)); end
    tests++; if (ch(out_data, 0) !== 16'h0005) begin fails++; $display("FAIL b2b_ch0: got %h want 0005", ch(out_data, 0)); end
    finish_run();
    begin_run();
    beats(16);
    tests++; if (ch(out_data, 2) !== rl(16'hFFFE)) begin fails++; $display("FAIL bias_new: got %h want %h", ch(out_data, 2), rl(16'hFFFE)); end
    tests++; if (ch(out_data, 0) !== 16'h0005) begin fails++; $display("FAIL bias_ch0: got %h want 0005", ch(out_data, 0)); end
    finish_run();
  endtask

  task automatic test_reset_midrun();
    begin_run();
    set_all(16'd1);
    beats(7);
    in_valid = 1;
    reset = 1;
    tick();
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL mid_reset_flags: got ov=%b busy=%b ir=%b want 0/0/0", out_valid, busy, in_ready); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL mid_reset_acc: got %h want 0", out_data); end
    reset = 0;
    in_valid = 0;
    tick();
    wr(5, 8'hFD);
    in_data = '0;
    in_data[1*SZ +: SZ] = 16'd1;
    begin_run();
    beats(16);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rerun_out_valid: got %b want 1", out_valid); end
    tests++; if (ch(out_data, 0) !== 16'h0005) begin fails++; $display("FAIL rerun_ch0: got %h want 0005", ch(out_data, 0)); end
    tests++; if (ch(out_data, 1) !== 16'h0010) begin fails++; $display("FAIL rerun_ch1: got %h want 0010", ch(out_data, 1)); end
    tests++; if (ch(out_data, 2) !== rl(16'hFFFE)) begin fails++; $display("FAIL rerun_ch2: got %h want %h", ch(out_data, 2), rl(16'hFFFE)); end
    tests++; if (ch(out_data, 5) !== rl(16'hFFFD)) begin fails++; $display("FAIL rerun_ch5: got %h want %h", ch(out_data, 5), rl(16'hFFFD)); end
    finish_run();
  endtask

  task automatic test_shift();
    s_wr_en = 1; s_wr_addr = 2'd2; s_wr_data = 8'hFE;
    tick();
    s_wr_addr = 2'd1; s_wr_data = 8'h7F;
    tick();
    s_wr_en = 0;
    s_start = 1;
    tick();
    s_start = 0;
    tick();
    tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL shift_in_ready: got %b want 1", s_in_ready); end
    tests++; if (s_out_data[2*16 +: 16] !== rl(16'hFFE0)) begin fails++; $display("FAIL shift_ch2: got %h want %h", s_out_data[2*16 +: 16], rl(16'hFFE0)); end
    tests++; if (s_out_data[1*16 +: 16] !== 16'h07F0) begin fails++; $display("FAIL shift_ch1: got %h want 07f0", s_out_data[1*16 +: 16]); end
    s_in_data = 64'h0000_0000_0000_0003;
    s_in_valid = 1;
    tick();
    s_in_valid = 0;
    tests++; if (s_out_valid !== 1'b1) begin fails++; $display("FAIL one_beat_valid: got %b want 1", s_out_valid); end
    tests++; if (s_out_data[15:0] !== 16'h0003) begin fails++; $display("FAIL one_beat_ch0: got %h want 0003", s_out_data[15:0]); end
    s_out_ready = 1;
    tick();
    s_out_ready = 0;
    tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL one_beat_release: got %b want 0", s_out_valid); end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_saturation();
    test_toggle();
    test_back_to_back();
    test_reset_midrun();
    test_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
